// File: rtl/clock_set_ctrl_pkg.sv
// Shared definitions for the clock set-mode controller: one-hot state
// encoding and default button timing derived from the board tick rate.
package clock_pkg;

    localparam logic [2:0] ST_RUN  = 3'b001;
    localparam logic [2:0] ST_SET  = 3'b010;
    localparam logic [2:0] ST_LOCK = 3'b100;

    typedef enum logic [2:0] {
        S_RUN  = ST_RUN,
        S_SET  = ST_SET,
        S_LOCK = ST_LOCK
    } state_t;

    // The set-mode logic runs from the 1 kHz front-panel tick.
    localparam int CLK_HZ             = 1000;
    localparam int DEF_HOLD_CYCLES    = CLK_HZ / 2;   // 0.5 s before auto-repeat
    localparam int DEF_REPEAT_CYCLES  = CLK_HZ / 10;  // 10 repeats per second
    localparam int DEF_TIMEOUT_CYCLES = CLK_HZ * 5;   // 5 s of inactivity

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Front-panel button inputs and set-mode outputs of the clock controller.
// No valid/ready handshake: buttons are active-low levels, inc_pulse and
// timed_out are single-cycle strobes that the counters must accept.
interface clock_set_ctrl_if #(
    parameter int NUM_FIELDS = 2
);
    logic                  set_n;
    logic [NUM_FIELDS-1:0] sel_n;
    logic                  inc_n;
    logic                  setting;
    logic [NUM_FIELDS-1:0] field_sel;
    logic                  inc_pulse;
    logic                  timed_out;

    modport master (
        output set_n, sel_n, inc_n,
        input  setting, field_sel, inc_pulse, timed_out
    );

    modport slave (
        input  set_n, sel_n, inc_n,
        output setting, field_sel, inc_pulse, timed_out
    );
endinterface

// File: rtl/clock_set_ctrl_btn_sync.sv
// Two-flop synchroniser for active-low buttons; resets to released (1).
module btn_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    // Two-stage capture of the asynchronous button levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/clock_set_ctrl.sv
// Set-mode controller: selects one of NUM_FIELDS fields, issues increment
// strobes with hold-to-auto-repeat, and drops back to run on inactivity.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int NUM_FIELDS     = 2,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES  = DEF_REPEAT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    clock_set_ctrl_if.slave     bus,
    output logic [2:0]          dbg_state
);
    localparam int FW   = $clog2(NUM_FIELDS);
    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW   = $clog2(HMAX + 1);
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW   = NUM_FIELDS + 2;

    localparam logic [HW-1:0]         HOLD_LIM  = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0]         REP_LIM   = HW'(REPEAT_CYCLES - 1);
    localparam logic [TW-1:0]         TO_LIM    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_FIELDS-1:0] FIELD_ONE = NUM_FIELDS'(1);

    logic [SW-1:0]         raw_btn;
    logic [SW-1:0]         sync_btn;
    logic                  set_lo;
    logic                  inc_lo;
    logic [NUM_FIELDS-1:0] sel_lo;
    logic                  sel_any;
    logic [FW-1:0]         sel_idx;

    state_t                state, state_n;
    logic [FW-1:0]         field_idx, idx_n;
    logic [TW-1:0]         to_cnt, to_n;
    logic [HW-1:0]         hold_cnt, hold_n, hold_lim;
    logic                  hold_act, act_n;
    logic                  rep, rep_n;
    logic                  inc_q;
    logic                  stay_set;
    logic                  fall;
    logic                  fire;
    logic                  tmo;

    logic                  setting_r;
    logic [NUM_FIELDS-1:0] field_sel_r;
    logic                  inc_pulse_r;
    logic                  timed_out_r;

    assign raw_btn = {bus.set_n, bus.inc_n, bus.sel_n};

    btn_sync #(.W(SW)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (raw_btn),
        .q     (sync_btn)
    );

    assign set_lo  = ~sync_btn[SW-1];
    assign inc_lo  = ~sync_btn[SW-2];
    assign sel_lo  = ~sync_btn[NUM_FIELDS-1:0];
    assign sel_any = |sel_lo;

    // Lowest-numbered pressed select button wins.
    always_comb begin
        sel_idx = '0;
        for (int i = NUM_FIELDS - 1; i >= 0; i--) begin
            if (sel_lo[i]) sel_idx = FW'(i);
        end
    end

    // Increment strobe generation and next-state/counter decode.
    always_comb begin
        state_n  = state;
        idx_n    = field_idx;
        to_n     = to_cnt;
        hold_n   = hold_cnt;
        act_n    = hold_act;
        rep_n    = rep;
        fire     = 1'b0;
        tmo      = 1'b0;
        stay_set = (state == S_SET) && set_lo;
        fall     = inc_lo && inc_q;
        hold_lim = rep ? REP_LIM : HOLD_LIM;

        // A hold only arms on a press seen inside SET, so a button already
        // held on entry needs a release and fresh press.
        if (stay_set && inc_lo) begin
            if (fall) begin
                fire   = 1'b1;
                act_n  = 1'b1;
                rep_n  = 1'b0;
                hold_n = '0;
            end else if (hold_act) begin
                if (hold_cnt == hold_lim) begin
                    fire   = 1'b1;
                    rep_n  = 1'b1;
                    hold_n = '0;
                end else begin
                    hold_n = hold_cnt + HW'(1);
                end
            end
        end else begin
            act_n  = 1'b0;
            rep_n  = 1'b0;
            hold_n = '0;
        end

        case (state)
            S_RUN: begin
                to_n = '0;
                if (set_lo && sel_any) begin
                    state_n = S_SET;
                    idx_n   = sel_idx;
                end
            end
            S_SET: begin
                if (!set_lo) begin
                    state_n = S_RUN;
                    to_n    = '0;
                end else if (sel_any) begin
                    idx_n = sel_idx;
                    to_n  = '0;
                end else if (fire) begin
                    to_n = '0;
                end else if (to_cnt == TO_LIM) begin
                    state_n = S_LOCK;
                    tmo     = 1'b1;
                    to_n    = '0;
                end else begin
                    to_n = to_cnt + TW'(1);
                end
            end
            S_LOCK: begin
                to_n = '0;
                if (!set_lo) state_n = S_RUN;
            end
            default: begin
                state_n = S_RUN;
                to_n    = '0;
            end
        endcase
    end

    // State, counters and outputs registered from the next-state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_RUN;
            field_idx   <= '0;
            to_cnt      <= '0;
            hold_cnt    <= '0;
            hold_act    <= 1'b0;
            rep         <= 1'b0;
            inc_q       <= 1'b1;
            setting_r   <= 1'b0;
            field_sel_r <= '0;
            inc_pulse_r <= 1'b0;
            timed_out_r <= 1'b0;
        end else begin
            state       <= state_n;
            field_idx   <= idx_n;
            to_cnt      <= to_n;
            hold_cnt    <= hold_n;
            hold_act    <= act_n;
            rep         <= rep_n;
            inc_q       <= sync_btn[SW-2];
            setting_r   <= (state_n == S_SET);
            field_sel_r <= (state_n == S_SET) ? (FIELD_ONE << idx_n) : '0;
            inc_pulse_r <= fire;
            timed_out_r <= tmo;
        end
    end

    assign bus.setting   = setting_r;
    assign bus.field_sel = field_sel_r;
    assign bus.inc_pulse = inc_pulse_r;
    assign bus.timed_out = timed_out_r;
    assign dbg_state     = state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with 3 fields and short timing.
module tb_clock_set_ctrl;
    logic clk;
    logic rst_n;
    logic [2:0] dbg_state;
    int compared;
    int mismatched;
    int n;
    logic [31:0] pulses;

    clock_set_ctrl_if #(.NUM_FIELDS(3)) bus ();

    clock_set_ctrl #(
        .NUM_FIELDS     (3),
        .HOLD_CYCLES    (8),
        .REPEAT_CYCLES  (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        bus.set_n  = 1'b1;
        bus.sel_n  = 3'b111;
        bus.inc_n  = 1'b1;
        tick(3);
        check("rst_setting",   32'(bus.setting),   32'h0);
        check("rst_field_sel", 32'(bus.field_sel), 32'h0);
        check("rst_inc_pulse", 32'(bus.inc_pulse), 32'h0);
        check("rst_timed_out", 32'(bus.timed_out), 32'h0);
        check("rst_state",     32'(dbg_state),     32'h1);
        rst_n = 1'b1;
        tick(1);

        // Enter SET on field 1; outputs appear three edges after the press.
        bus.set_n = 1'b0;
        bus.sel_n = 3'b101;
        tick(1);
        bus.sel_n = 3'b111;
        tick(1);
        check("enter_early", 32'(bus.setting), 32'h0);
        tick(1);
        check("enter_setting", 32'(bus.setting),   32'h1);
        check("enter_field",   32'(bus.field_sel), 32'h2);

        // All selects pressed: lowest wins.
        bus.sel_n = 3'b000;
        tick(1);
        bus.sel_n = 3'b111;
        tick(2);
        check("sel_lowest", 32'(bus.field_sel), 32'h1);
        bus.sel_n = 3'b011;
        tick(1);
        bus.sel_n = 3'b111;
        tick(1);
        check("sel_hold_old", 32'(bus.field_sel), 32'h1);
        tick(1);
        check("sel_field2", 32'(bus.field_sel), 32'h4);

        // Releasing set returns to run after three edges.
        bus.set_n = 1'b1;
        tick(2);
        check("exit_early", 32'(bus.setting), 32'h1);
        tick(1);
        check("exit_setting", 32'(bus.setting),   32'h0);
        check("exit_field",   32'(bus.field_sel), 32'h0);

        // inc already held when SET is entered gives no pulse.
        bus.inc_n = 1'b0;
        tick(3);
        bus.set_n = 1'b0;
        bus.sel_n = 3'b110;
        tick(1);
        bus.sel_n = 3'b111;
        tick(2);
        check("held_enter_setting", 32'(bus.setting),   32'h1);
        check("held_enter_field",   32'(bus.field_sel), 32'h1);
        n = 0;
        for (int t = 1; t <= 8; t++) begin
            if (t == 6) bus.inc_n = 1'b1;
            tick(1);
            if (bus.inc_pulse === 1'b1) n++;
        end
        check("held_no_pulse", 32'(n), 32'h0);

        // Fresh 20-cycle press: pulses at +3, then +8, +4, +4 apart.
        bus.inc_n = 1'b0;
        pulses = '0;
        for (int t = 1; t <= 24; t++) begin
            tick(1);
            if (t == 20) bus.inc_n = 1'b1;
            pulses[t] = bus.inc_pulse;
        end
        check("repeat_pattern", pulses, 32'h0008_8808);

        // Idle in SET: timeout 16 edges after the last pulse (11 from here).
        n = 0;
        while (bus.timed_out !== 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
        check("timeout_latency", 32'(n), 32'd11);
        check("timeout_setting", 32'(bus.setting),   32'h0);
        check("timeout_field",   32'(bus.field_sel), 32'h0);
        check("timeout_state",   32'(dbg_state),     32'h4);
        tick(1);
        check("timeout_width", 32'(bus.timed_out), 32'h0);

        // Still holding set: a select press must not re-enter SET.
        bus.sel_n = 3'b110;
        tick(1);
        bus.sel_n = 3'b111;
        tick(3);
        check("lock_setting", 32'(bus.setting), 32'h0);
        check("lock_state",   32'(dbg_state),   32'h4);
        bus.set_n = 1'b1;
        tick(3);
        check("lock_release_state", 32'(dbg_state), 32'h1);
        bus.set_n = 1'b0;
        bus.sel_n = 3'b101;
        tick(1);
        bus.sel_n = 3'b111;
        tick(2);
        check("reenter_setting", 32'(bus.setting),   32'h1);
        check("reenter_field",   32'(bus.field_sel), 32'h2);

        // Auto-repeat, then asynchronous reset during a repeat pulse.
        bus.inc_n = 1'b0;
        tick(2);
        check("press_early", 32'(bus.inc_pulse), 32'h0);
        tick(1);
        check("press_pulse", 32'(bus.inc_pulse), 32'h1);
        tick(1);
        check("press_width", 32'(bus.inc_pulse), 32'h0);
        tick(7);
        check("repeat_pulse", 32'(bus.inc_pulse), 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_inc_pulse", 32'(bus.inc_pulse), 32'h0);
        check("async_setting",   32'(bus.setting),   32'h0);
        check("async_field",     32'(bus.field_sel), 32'h0);
        check("async_timed_out", 32'(bus.timed_out), 32'h0);
        check("async_state",     32'(dbg_state),     32'h1);
        bus.set_n = 1'b1;
        bus.inc_n = 1'b1;
        bus.sel_n = 3'b111;
        tick(2);
        rst_n = 1'b1;
        n = 0;
        for (int t = 0; t < 20; t++) begin
            tick(1);
            if (bus.inc_pulse !== 1'b0 || bus.setting !== 1'b0 || bus.timed_out !== 1'b0) n++;
        end
        check("post_reset_quiet", 32'(n), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
